tile_renderer: RTL and testbench

Pixel source for the VGA output path. Consumes the controller's next-pixel coordinates and returns each pixel's R/G/B bits in the same cycle, looked up from an on-chip tile map. Accepts a byte-wide command stream from the host-side interface (SPI byte decoder) on a valid/ready handshake. A small FSM executes set, fill and clear operations into the tile map, one tile per cycle.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/tile_map_mem.sv | 31 +++
 rtl/tile_renderer.sv | 169 ++++++++++++++++
 tb/tb_tile_renderer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing parameters plus the tile renderer's opcode, state and colour types.
package vga_pkg;

  typedef struct packed {
    int h_visible;
    int h_front;
    int h_sync;
    int h_back;
    int v_visible;
    int v_front;
    int v_sync;
    int v_back;
    int pixel_x_bits;
    int pixel_y_bits;
  } vga_params_t;

  localparam vga_params_t VGA_640x480 = '{
    h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
    pixel_x_bits: 10, pixel_y_bits: 10
  };

  localparam int TILE_SHIFT_DEFAULT = 5;

  typedef enum logic [3:0] {
    OP_SET   = 4'h1,
    OP_FILL  = 4'h2,
    OP_CLEAR = 4'h3
  } tile_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARGS = 2'd1,
    ST_EXEC = 2'd2
  } tile_state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } tile_rgb_t;

endpackage

// File: rtl/tile_map_mem.sv
// Flop-based tile colour map: one synchronous write port with clear, one combinational read port.
module tile_map_mem
  import vga_pkg::*;
#(
  parameter int DEPTH  = 300,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tile_rgb_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output tile_rgb_t         rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  tile_rgb_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && waddr <= LAST) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST) ? mem[raddr] : '0;

endmodule

// File: rtl/tile_renderer.sv
// Tile-based pixel source: combinational colour lookup plus a byte command FSM that
// walks SET/FILL/CLEAR rectangles into the tile map one tile per cycle.
module tile_renderer
  import vga_pkg::*;
#(
  parameter vga_params_t params     = VGA_640x480,
  parameter int          TILE_SHIFT = TILE_SHIFT_DEFAULT
) (
  input  logic                           VGA_clk,
  input  logic                           reset,
  input  logic [params.pixel_x_bits-1:0] pixel_x_target_next,
  input  logic [params.pixel_y_bits-1:0] pixel_y_target_next,
  output logic                           pixel_value_next_R,
  output logic                           pixel_value_next_G,
  output logic                           pixel_value_next_B,
  input  logic [7:0]                     cmd_data,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  output logic                           busy,
  output logic                           cmd_err
);

  localparam int XB      = params.pixel_x_bits;
  localparam int YB      = params.pixel_y_bits;
  localparam int TILES_X = params.h_visible >> TILE_SHIFT;
  localparam int TILES_Y = params.v_visible >> TILE_SHIFT;
  localparam int DEPTH   = TILES_X * TILES_Y;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam logic [7:0] MAX_TX = 8'(TILES_X - 1);
  localparam logic [7:0] MAX_TY = 8'(TILES_Y - 1);

  tile_state_t       state, state_next;
  tile_op_t          op_q;
  tile_rgb_t         colour_q, rd_rgb;
  logic [1:0]        arg_cnt, arg_last;
  logic [7:0]        arg_q [4];
  logic [7:0]        walk_x, walk_y, rect_x0, rect_x1, rect_y1, fill_x1, fill_y1;
  logic              exec_skip, ready_en, fire, tile_we, in_map;
  logic [3:0]        byte_op;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [XB-1:0]     tile_x;
  logic [YB-1:0]     tile_y;
  logic              unused_cmd_bit;

  assign unused_cmd_bit = cmd_data[3];
  assign byte_op        = cmd_data[7:4];
  assign busy           = (state == ST_EXEC);
  assign cmd_ready      = ready_en && (state != ST_EXEC);
  assign fire           = cmd_valid && cmd_ready;
  assign arg_last       = (op_q == OP_SET) ? 2'd1 : 2'd3;
  assign fill_x1        = (arg_q[2] > MAX_TX) ? MAX_TX : arg_q[2];
  assign fill_y1        = (cmd_data > MAX_TY) ? MAX_TY : cmd_data;
  assign wr_addr        = ADDR_W'(32'(walk_y) * 32'(TILES_X) + 32'(walk_x));

  assign tile_x  = pixel_x_target_next >> TILE_SHIFT;
  assign tile_y  = pixel_y_target_next >> TILE_SHIFT;
  assign in_map  = (tile_x < XB'(TILES_X)) && (tile_y < YB'(TILES_Y));
  assign rd_addr = ADDR_W'(32'(tile_y) * 32'(TILES_X) + 32'(tile_x));
  assign {pixel_value_next_R, pixel_value_next_G, pixel_value_next_B} = in_map ? rd_rgb : 3'b000;

  tile_map_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_map (
    .clk   (VGA_clk),
    .clear (reset),
    .we    (tile_we),
    .waddr (wr_addr),
    .wdata (colour_q),
    .raddr (rd_addr),
    .rdata (rd_rgb)
  );

  always_ff @(posedge VGA_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tile_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          if (byte_op == OP_SET || byte_op == OP_FILL) state_next = ST_ARGS;
          else if (byte_op == OP_CLEAR)                state_next = ST_EXEC;
        end
      end
      ST_ARGS: begin
        if (fire && arg_cnt == arg_last) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        tile_we = !exec_skip;
        if (exec_skip || (walk_x == rect_x1 && walk_y == rect_y1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Rectangle bounds are latched when the last byte arrives; the walker then runs x-inner.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      ready_en  <= 1'b0;
      cmd_err   <= 1'b0;
      op_q      <= OP_SET;
      colour_q  <= '0;
      arg_cnt   <= 2'd0;
      walk_x    <= '0;
      walk_y    <= '0;
      rect_x0   <= '0;
      rect_x1   <= '0;
      rect_y1   <= '0;
      exec_skip <= 1'b0;
      for (int i = 0; i < 4; i++) arg_q[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      cmd_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            op_q     <= tile_op_t'(byte_op);
            colour_q <= tile_rgb_t'(cmd_data[2:0]);
            arg_cnt  <= 2'd0;
            if (byte_op == OP_CLEAR) begin
              walk_x    <= '0;
              walk_y    <= '0;
              rect_x0   <= '0;
              rect_x1   <= MAX_TX;
              rect_y1   <= MAX_TY;
              exec_skip <= 1'b0;
            end else if (byte_op != OP_SET && byte_op != OP_FILL) begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_ARGS: begin
          if (fire) begin
            arg_q[arg_cnt] <= cmd_data;
            arg_cnt        <= arg_cnt + 2'd1;
            if (arg_cnt == arg_last) begin
              walk_x  <= arg_q[0];
              rect_x0 <= arg_q[0];
              if (op_q == OP_SET) begin
                walk_y    <= cmd_data;
                rect_x1   <= arg_q[0];
                rect_y1   <= cmd_data;
                exec_skip <= (arg_q[0] > MAX_TX) || (cmd_data > MAX_TY);
              end else begin
                walk_y    <= arg_q[1];
                rect_x1   <= fill_x1;
                rect_y1   <= fill_y1;
                exec_skip <= (arg_q[0] > fill_x1) || (arg_q[1] > fill_y1);
              end
            end
          end
        end
        ST_EXEC: begin
          if (!exec_skip) begin
            if (walk_x == rect_x1) begin
              walk_x <= rect_x0;
              walk_y <= walk_y + 8'd1;
            end else begin
              walk_x <= walk_x + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench: directed scenarios plus random commands against a tile-array reference model.
module tb_tile_renderer;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       pix_r, pix_g, pix_b;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready, busy, cmd_err;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model [15][20];

  always #5 vga_clk = ~vga_clk;

  tile_renderer dut (
    .VGA_clk             (vga_clk),
    .reset               (reset),
    .pixel_x_target_next (pixel_x),
    .pixel_y_target_next (pixel_y),
    .pixel_value_next_R  (pix_r),
    .pixel_value_next_G  (pix_g),
    .pixel_value_next_B  (pix_b),
    .cmd_data            (cmd_data),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .busy                (busy),
    .cmd_err             (cmd_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] refPixel(input int x, input int y);
    int tx = x / 32;
    int ty = y / 32;
    if (tx < 20 && ty < 15) return model[ty][tx];
    return 3'b000;
  endfunction

  task automatic modelClear(input logic [2:0] c);
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++) model[y][x] = c;
  endtask

  // Applies one command's effect to the model and returns its EXEC length and error flag.
  task automatic modelCommand(input logic [7:0] b0, input int a0, input int a1, input int a2, input int a3,
                              output int cycles, output bit err);
    int x1, y1;
    err = 0;
    cycles = 0;
    case (b0[7:4])
      4'h1: begin
        cycles = 1;
        if (a0 < 20 && a1 < 15) model[a1][a0] = b0[2:0];
      end
      4'h2: begin
        x1 = (a2 > 19) ? 19 : a2;
        y1 = (a3 > 14) ? 14 : a3;
        if (a0 > x1 || a1 > y1) cycles = 1;
        else
          for (int y = a1; y <= y1; y++)
            for (int x = a0; x <= x1; x++) begin
              model[y][x] = b0[2:0];
              cycles++;
            end
      end
      4'h3: begin
        modelClear(b0[2:0]);
        cycles = 300;
      end
      default: err = 1;
    endcase
  endtask

  task automatic checkPixel(input int x, input int y, input string tag);
    @(negedge vga_clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    #1;
    checkOutput(tag, {29'd0, pix_r, pix_g, pix_b}, {29'd0, refPixel(x, y)});
  endtask

  task automatic scanMap(input string tag);
    for (int ty = 0; ty < 15; ty++)
      for (int tx = 0; tx < 20; tx++)
        checkPixel(tx * 32 + $urandom_range(31), ty * 32 + $urandom_range(31), tag);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    @(negedge vga_clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && guard < 2000) begin
      @(negedge vga_clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("ready_timeout", 0, 1);
    @(posedge vga_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  // Sends a whole command, then checks cmd_err, the busy length and the return of cmd_ready.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] a3, input string tag);
    int cycles, busy_cnt;
    bit err;
    sendByte(b0);
    if (b0[7:4] == 4'h1 || b0[7:4] == 4'h2) begin
      sendByte(a0);
      sendByte(a1);
    end
    if (b0[7:4] == 4'h2) begin
      sendByte(a2);
      sendByte(a3);
    end
    modelCommand(b0, int'(a0), int'(a1), int'(a2), int'(a3), cycles, err);
    @(negedge vga_clk);
    checkOutput({tag, "_err"}, {31'd0, cmd_err}, {31'd0, err});
    busy_cnt = 0;
    while (busy && busy_cnt < 1000) begin
      busy_cnt++;
      @(negedge vga_clk);
    end
    checkOutput({tag, "_busy"}, busy_cnt, cycles);
    checkOutput({tag, "_ready"}, {31'd0, cmd_ready}, 1);
    @(negedge vga_clk);
    checkOutput({tag, "_err_clr"}, {31'd0, cmd_err}, 0);
  endtask

  task automatic doReset(input int hold);
    @(negedge vga_clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (hold) begin
      @(negedge vga_clk);
      checkOutput("rst_ready", {31'd0, cmd_ready}, 0);
      checkOutput("rst_busy", {31'd0, busy}, 0);
      checkOutput("rst_err", {31'd0, cmd_err}, 0);
    end
    reset = 1'b0;
    modelClear(3'b000);
    #1;
    checkOutput("rst_hold_ready", {31'd0, cmd_ready}, 0);
    @(negedge vga_clk);
    checkOutput("rst_ready_up", {31'd0, cmd_ready}, 1);
    checkOutput("rst_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low_cnt, cyc;
    bit err;
    logic [7:0] b0, a0, a1, a2, a3;

    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h15;
    pixel_x   = 10'd100;
    pixel_y   = 10'd70;
    modelClear(3'b000);
    repeat (3) begin
      @(negedge vga_clk);
      pixel_x = 10'($urandom_range(639));
      pixel_y = 10'($urandom_range(479));
      #1;
      checkOutput("reset_ready", {31'd0, cmd_ready}, 0);
      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_err", {31'd0, cmd_err}, 0);
      checkOutput("reset_pixel", {29'd0, pix_r, pix_g, pix_b}, 0);
    end
    @(negedge vga_clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checkOutput("release_hold", {31'd0, cmd_ready}, 0);
    @(negedge vga_clk);
    checkOutput("release_ready", {31'd0, cmd_ready}, 1);
    scanMap("reset_scan");

    applyStimulus(8'h15, 8'd3, 8'd2, 8'd0, 8'd0, "set");
    checkPixel(96, 64, "set_corner_lo");
    checkOutput("set_rgb_lo", {29'd0, pix_r, pix_g, pix_b}, 3'b101);
    checkPixel(127, 95, "set_corner_hi");
    checkOutput("set_rgb_hi", {29'd0, pix_r, pix_g, pix_b}, 3'b101);
    checkPixel(95, 64, "set_left_nb");
    checkOutput("set_left_rgb", {29'd0, pix_r, pix_g, pix_b}, 3'b000);

    applyStimulus(8'h27, 8'd18, 8'd13, 8'd25, 8'd40, "fill_clamp");
    checkPixel(19 * 32 + 31, 14 * 32 + 31, "fill_corner");
    checkOutput("fill_rgb", {29'd0, pix_r, pix_g, pix_b}, 3'b111);
    scanMap("fill_scan");

    applyStimulus(8'h2C, 8'd9, 8'd3, 8'd4, 8'd8, "fill_empty");
    applyStimulus(8'h16, 8'd20, 8'd1, 8'd0, 8'd0, "set_oob");

    sendByte(8'h32);
    modelCommand(8'h32, 0, 0, 0, 0, cyc, err);
    cmd_valid = 1'b1;
    cmd_data  = 8'h9F;
    low_cnt   = 0;
    @(negedge vga_clk);
    while (!cmd_ready && low_cnt < 1000) begin
      low_cnt++;
      @(negedge vga_clk);
    end
    checkOutput("bp_ready_low", low_cnt, 300);
    @(posedge vga_clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge vga_clk);
    checkOutput("bp_next_byte", {31'd0, cmd_err}, 1);
    scanMap("clear_scan");

    applyStimulus(8'h9F, 8'd0, 8'd0, 8'd0, 8'd0, "bad_op");
    scanMap("bad_op_scan");
    applyStimulus(8'h14, 8'd0, 8'd0, 8'd0, 8'd0, "set_after_bad");
    checkPixel(5, 5, "set_after_bad_px");

    sendByte(8'h37);
    repeat (100) @(negedge vga_clk);
    checkOutput("mid_clear_busy", {31'd0, busy}, 1);
    doReset(1);
    scanMap("mid_reset_scan");

    sendByte(8'h24);
    sendByte(8'h05);
    doReset(1);
    applyStimulus(8'h16, 8'd1, 8'd1, 8'd0, 8'd0, "post_trunc_set");
    checkPixel(40, 40, "post_trunc_px");
    checkOutput("post_trunc_rgb", {29'd0, pix_r, pix_g, pix_b}, 3'b110);
    scanMap("post_trunc_scan");

    for (int n = 0; n < 30; n++) begin
      a0 = 8'($urandom_range(23));
      a1 = 8'($urandom_range(17));
      a2 = 8'($urandom_range(30));
      a3 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(17));
      case ($urandom_range(9))
        0, 1, 2, 3:    b0 = {4'h1, 4'($urandom)};
        4, 5, 6, 7:    b0 = {4'h2, 4'($urandom)};
        8:             b0 = {4'h3, 4'($urandom)};
        default:       b0 = {4'(4 + $urandom_range(11)), 4'($urandom)};
      endcase
      applyStimulus(b0, a0, a1, a2, a3, "rand_cmd");
      for (int k = 0; k < 20; k++)
        checkPixel($urandom_range(1023), $urandom_range(1023), "rand_px");
    end
    scanMap("final_scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
